// File: rtl/shield_width_serializer.sv
// ---------------------------------------------------------------------------
// shield_width_serializer
//
// Takes a wide line of WORDS words (OUT_W bits each) and emits the words one
// per cycle, in index order, from word 0 up to and including the line's
// last valid word. Each line can carry fewer than WORDS valid words. The
// final word of a line can transfer in the same cycle that the next line is
// accepted, so back-to-back lines stream without a bubble.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high reset
//   in_valid     input line valid
//   in_ready     line accepted this cycle (in_valid && in_ready)
//   in_data      input line; word i = in_data[OUT_W*i +: OUT_W]
//   in_last_idx  index of the last valid word in the line
//   in_last      line ends a packet
//   out_valid    out_data valid
//   out_ready    downstream accepts the current word
//   out_data     current word of the held line
//   out_sel      index of the current word within the held line
//   out_last     current word is the final word of a packet
// ---------------------------------------------------------------------------
module shield_width_serializer #(
  parameter int OUT_W = 64,
  parameter int WORDS = 8,
  localparam int IN_W  = OUT_W * WORDS,
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [IDX_W-1:0] in_last_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_sel,
  output logic             out_last
);

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t state, state_next;

  // Held line, viewed as an array of words so the output mux is a plain index.
  logic [WORDS-1:0][OUT_W-1:0] line_q;
  logic [IDX_W-1:0]            last_idx_q;
  logic                        last_q;

  logic is_final;   // current word is the last valid word of the held line
  logic out_fire;
  logic in_fire;

  assign is_final = (out_sel == last_idx_q);
  assign out_fire = out_valid && out_ready;
  assign in_fire  = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: begin
        if (in_fire) state_next = SEND;
      end
      SEND: begin
        // Final word leaving: refill from a new line if one arrives this
        // cycle, otherwise drop back to EMPTY.
        if (out_fire && is_final) state_next = in_fire ? SEND : EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_last  = 1'b0;
    unique case (state)
      EMPTY: begin
        in_ready = 1'b1;
      end
      SEND: begin
        out_valid = 1'b1;
        // Combinational out_ready -> in_ready: a new line may enter exactly
        // when the final word of the held line is leaving.
        in_ready  = out_ready && is_final;
        out_last  = is_final && last_q;
      end
      default: ;
    endcase
  end

  assign out_data = line_q[out_sel];

  // -------------------------------------------------------------------------
  // Datapath: word pointer and line metadata
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_sel    <= '0;
      last_idx_q <= '0;
      last_q     <= 1'b0;
    end else if (in_fire) begin
      out_sel    <= '0;
      last_idx_q <= in_last_idx;
      last_q     <= in_last;
    end else if (out_fire && !is_final) begin
      out_sel    <= out_sel + IDX_W'(1);
    end
  end

  // NOTE: the line storage is deliberately not reset; it is only observed
  // while out_valid is high, and that requires a line to have been loaded.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      line_q <= in_data;
    end
  end

endmodule

// File: tb/tb_shield_width_serializer.sv
// ---------------------------------------------------------------------------
// tb_shield_width_serializer
//
// Directed scenarios for the line-to-word serializer plus a randomized
// stall/valid stress run checked against a queue of expected words.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 1 further time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_shield_width_serializer;

  localparam int OUT_W = 64;
  localparam int WORDS = 8;
  localparam int IN_W  = OUT_W * WORDS;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  sel;
    logic        last;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic [2:0]      in_last_idx;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_data;
  logic [2:0]      out_sel;
  logic            out_last;

  int n_checks = 0;
  int n_fail   = 0;

  shield_width_serializer #(
    .OUT_W(OUT_W),
    .WORDS(WORDS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last_idx(in_last_idx),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  // Advance one clock and land 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line whose word i is base + i.
  function automatic logic [IN_W-1:0] ramp_line(input logic [63:0] base);
    logic [IN_W-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*64 +: 64] = base + 64'(i);
    return l;
  endfunction

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_last_idx = '0; in_last = 1'b0;
    tick();
    tick();
    #1;
    n_checks++;
    if ({out_valid, out_last, in_ready, out_sel} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_held: valid/last/ready/sel got %b%b%b/%0d want 001/0",
               out_valid, out_last, in_ready, out_sel);
    end
    reset = 1'b0;
    tick();
    #1;
    n_checks++;
    if ({out_valid, out_last, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_release: valid/last/ready got %b%b%b want 001",
               out_valid, out_last, in_ready);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_full_line();
    logic [IN_W-1:0] line;
    line = ramp_line(64'h5a5a_0000_0000_0000);
    line[63:0]    = 64'hdeadbeefdeadbeef;
    line[127:64]  = 64'h10101010ffffffff;
    line[511:448] = 64'hbbbbbbbbbbbbbbbb;
    in_data = line; in_last_idx = 3'd7; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_accept: in_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++;
      if ({out_valid, in_ready, out_sel, out_last, out_data} !==
          {1'b1, (k == 7), 3'(k), (k == 7), line[k*64 +: 64]}) begin
        n_fail++;
        $display("FAIL full_word[%0d]: v/r/sel/last/data got %b/%b/%0d/%b/%h want 1/%b/%0d/%b/%h",
                 k, out_valid, in_ready, out_sel, out_last, out_data,
                 (k == 7), k, (k == 7), line[k*64 +: 64]);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL full_empty: valid/ready got %b%b want 01", out_valid, in_ready);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_short_line();
    logic [IN_W-1:0] line;
    line = ramp_line(64'h0000_3000_0000_0000);
    in_data = line; in_last_idx = 3'd2; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({out_valid, in_ready, out_sel, out_last, out_data} !==
          {1'b1, (k == 2), 3'(k), 1'b0, line[k*64 +: 64]}) begin
        n_fail++;
        $display("FAIL short_word[%0d]: v/r/sel/last/data got %b/%b/%0d/%b/%h want 1/%b/%0d/0/%h",
                 k, out_valid, in_ready, out_sel, out_last, out_data,
                 (k == 2), k, line[k*64 +: 64]);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL short_empty: valid/ready got %b%b want 01", out_valid, in_ready);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [IN_W-1:0] line_a, line_b;
    line_a = ramp_line(64'h0000_00a0_0000_0000);
    line_b = ramp_line(64'h0000_00b0_0000_0000);
    in_data = line_a; in_last_idx = 3'd7; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    // Second line presented continuously while the first drains.
    in_data = line_b; in_last_idx = 3'd0; in_last = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++;
      if ({out_valid, in_ready, out_sel, out_last, out_data} !==
          {1'b1, (k == 7), 3'(k), (k == 7), line_a[k*64 +: 64]}) begin
        n_fail++;
        $display("FAIL b2b_a_word[%0d]: v/r/sel/last/data got %b/%b/%0d/%b/%h want 1/%b/%0d/%b/%h",
                 k, out_valid, in_ready, out_sel, out_last, out_data,
                 (k == 7), k, (k == 7), line_a[k*64 +: 64]);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_sel, out_last, out_data} !==
        {1'b1, 1'b1, 3'd0, 1'b1, line_b[63:0]}) begin
      n_fail++;
      $display("FAIL b2b_b_word: v/r/sel/last/data got %b/%b/%0d/%b/%h want 1/1/0/1/%h",
               out_valid, in_ready, out_sel, out_last, out_data, line_b[63:0]);
    end
    tick();
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_empty: valid/ready got %b%b want 01", out_valid, in_ready);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [IN_W-1:0] line;
    line = ramp_line(64'h0000_7700_0000_0000);
    in_data = line; in_last_idx = 3'd7; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();  // word 0
    tick();  // word 1
    tick();  // word 2
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if ({out_valid, in_ready, out_sel, out_last, out_data} !==
          {1'b1, 1'b0, 3'd3, 1'b0, line[3*64 +: 64]}) begin
        n_fail++;
        $display("FAIL stall[%0d]: v/r/sel/last/data got %b/%b/%0d/%b/%h want 1/0/3/0/%h",
                 c, out_valid, in_ready, out_sel, out_last, out_data, line[3*64 +: 64]);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      #1;
      n_checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 3'(k), line[k*64 +: 64]}) begin
        n_fail++;
        $display("FAIL resume_word[%0d]: v/sel/data got %b/%0d/%h want 1/%0d/%h",
                 k, out_valid, out_sel, out_data, k, line[k*64 +: 64]);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL stall_empty: valid/ready got %b%b want 01", out_valid, in_ready);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [IN_W-1:0] line, line2;
    line  = ramp_line(64'h0000_9900_0000_0000);
    line2 = ramp_line(64'h0000_ab00_0000_0000);
    in_data = line; in_last_idx = 3'd7; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #1;
    n_checks++;
    if ({out_valid, out_sel} !== {1'b1, 3'd5}) begin
      n_fail++; $display("FAIL midrst_pre: valid/sel got %b/%0d want 1/5", out_valid, out_sel);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_sel, out_last} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_post: v/r/sel/last got %b/%b/%0d/%b want 0/1/0/0",
               out_valid, in_ready, out_sel, out_last);
    end
    in_data = line2; in_last_idx = 3'd1; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if ({out_valid, out_sel, out_last, out_data} !==
          {1'b1, 3'(k), (k == 1), line2[k*64 +: 64]}) begin
        n_fail++;
        $display("FAIL midrst_new[%0d]: v/sel/last/data got %b/%0d/%b/%h want 1/%0d/%b/%h",
                 k, out_valid, out_sel, out_last, out_data, k, (k == 1), line2[k*64 +: 64]);
      end
      tick();
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stress();
    exp_t            q[$];
    exp_t            e;
    int              sent    = 0;
    int              cycles  = 0;
    bit              pending = 1'b0;
    logic [IN_W-1:0] line    = '0;
    logic [2:0]      idx     = '0;
    logic            lst     = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    while ((sent < 1000 || pending || q.size() > 0) && cycles < 60000) begin
      if (!pending && sent < 1000) begin
        for (int w = 0; w < IN_W / 32; w++) line[w*32 +: 32] = $urandom();
        idx     = 3'($urandom_range(0, 7));
        lst     = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      in_data     = line;
      in_last_idx = idx;
      in_last     = lst;
      in_valid    = pending && ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL stress_extra: got word sel %0d data %h, want no word", out_sel, out_data);
        end else begin
          e = q.pop_front();
          if ({out_sel, out_last, out_data} !== {e.sel, e.last, e.data}) begin
            n_fail++;
            $display("FAIL stress_word: sel/last/data got %0d/%b/%h want %0d/%b/%h",
                     out_sel, out_last, out_data, e.sel, e.last, e.data);
          end
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i <= int'(idx); i++) begin
          e.data = line[i*64 +: 64];
          e.sel  = 3'(i);
          e.last = lst && (i == int'(idx));
          q.push_back(e);
        end
        sent++;
        pending = 1'b0;
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (sent != 1000 || q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stress_done: lines %0d left %0d valid %b after %0d cycles, want 1000/0/0",
               sent, q.size(), out_valid, cycles);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_full_line();
    test_short_line();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shield_width_serializer.md
SHIELD_WIDTH_SERIALIZER -- requirements
Module: shield_width_serializer

Interface
REQ-001 Parameter OUT_W, default 64: output word width in bits.
REQ-002 Parameter WORDS, default 8: words per input line; input width = OUT_W*WORDS = 512; index width = 3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  input line valid.
REQ-006 in_ready  output  1  block accepts the line this cycle.
REQ-007 in_data  input  512  line; word i = in_data[64i+63:64i].
REQ-008 in_last_idx  input  3  index of the last valid word in the line (0..7).
REQ-009 in_last  input  1  line ends a packet.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_data  output  64  current word, selected from the held line by out_sel.
REQ-013 out_sel  output  3  index of the current word within the held line.
REQ-014 out_last  output  1  current word is the final word of a packet.

Function
REQ-015 The block SHALL have two states: EMPTY (no line held) and SEND (line held, words being emitted).
REQ-016 Input handshake: a line is accepted when in_valid && in_ready; accepted in_data, in_last_idx, in_last are registered into line_q, last_idx_q, last_q.
REQ-017 In EMPTY: in_ready=1, out_valid=0; on acceptance, go to SEND with out_sel=0 on the next cycle.
REQ-018 In SEND: out_valid=1, out_data=line_q[64*out_sel+63:64*out_sel]; out_data, out_sel, out_last SHALL remain stable while out_valid && !out_ready.
REQ-019 Output handshake: a word transfers when out_valid && out_ready; out_sel SHALL then increment by 1 unless out_sel==last_idx_q.
REQ-020 out_last SHALL be 1 only when out_sel==last_idx_q && last_q; all other words drive 0.
REQ-021 in_ready in SEND SHALL be 1 only in the cycle where the final word (out_sel==last_idx_q) transfers; combinational path out_ready->in_ready is permitted.
REQ-022 When the final word transfers and a new line is accepted in the same cycle, the block SHALL stay in SEND, load the new line, and set out_sel=0 with no bubble cycle.
REQ-023 When the final word transfers with no new line accepted, the block SHALL go to EMPTY.
REQ-024 in_last_idx=0 SHALL yield exactly one word per line; in_last_idx=7 SHALL yield eight words; out_sel never exceeds last_idx_q and never wraps past 7.
REQ-025 Latency: first word of an accepted line is valid on the cycle after acceptance; sustained throughput is one word per cycle when out_ready=1.
REQ-026 Words SHALL be emitted strictly in index order 0..last_idx_q; no word dropped or duplicated.

Reset
REQ-027 While reset=1 at a clock edge: state=EMPTY, out_sel=0, last_idx_q=0, last_q=0; out_valid=0, out_last=0, in_ready=1 after that edge.
REQ-028 line_q SHALL not require reset; out_data is don't-care while out_valid=0.
REQ-029 Reset asserted mid-line SHALL discard the held line and remaining words; the next word emitted after reset is word 0 of a newly accepted line.

Verification
REQ-030 Single full line: in_data[63:0]=64'hdeadbeefdeadbeef, [127:64]=64'h10101010ffffffff, [511:448]=64'hbbbbbbbbbbbbbbbb, in_last_idx=7, in_last=1, out_ready=1 -> 8 words on 8 consecutive cycles, sel 0..7, word1=64'h10101010ffffffff, word7=64'hbbbbbbbbbbbbbbbb with out_last=1 only on word7.
REQ-031 Short line: in_last_idx=2, in_last=0 -> exactly 3 words (sel 0,1,2), out_last=0 throughout, then EMPTY with in_ready=1.
REQ-032 Back-to-back: two lines presented continuously, in_last_idx=7 and 0, out_ready=1 -> 9 words on 9 consecutive cycles, in_ready pulses on word7 of line 1, no bubble.
REQ-033 Backpressure: out_ready=0 for 5 cycles while out_sel=3 -> out_data, out_sel=3, out_valid=1 held unchanged; in_ready=0; resumes with sel 4 after out_ready=1.
REQ-034 Reset mid-operation: reset=1 for 1 cycle at out_sel=5 -> next cycle out_valid=0, in_ready=1, out_sel=0; next line emits from word 0.
REQ-035 Random stall/valid stress (1000 lines, random in_last_idx, random out_ready) -> scoreboard matches every word and out_last flag in order.
